bin_to_bcd_seq: RTL and testbench
=================================

BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

Interface
REQ-001 SHALL have parameter DATA_W, default 13, meaning width of the binary operand (the 13-bit result of the square/cube/factorial stage).
REQ-002 SHALL have parameter DIGITS, default 4, meaning number of BCD digits produced.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port start  input  1  request to convert bin_in; sampled only in IDLE.
REQ-006 SHALL have port bin_in  input  DATA_W  unsigned binary operand; captured on the accepting edge.
REQ-007 SHALL have port busy  output  1  high while a conversion is in progress (CONV state).
REQ-008 SHALL have port done  output  1  single-cycle pulse; bcd_out is valid from this cycle onward.
REQ-009 SHALL have port bcd_out  output  4*DIGITS  packed BCD result; the most significant digit occupies the top nibble.

Function
REQ-010 SHALL implement the state machine IDLE -> CONV -> DONE -> IDLE; no other states are reachable.
REQ-011 IDLE with start=1 at edge k SHALL capture bin_in into the shift register, clear the BCD scratch digits, load the iteration counter with DATA_W, and enter CONV.
REQ-012 IDLE with start=0 SHALL hold all registers unchanged.
REQ-013 CONV SHALL perform one shift-add-3 (double-dabble) iteration per cycle, giving exactly DATA_W iterations on edges k+1 .. k+DATA_W.
REQ-014 Each iteration SHALL first add 3 to every scratch digit that is >= 5, then shift {scratch, operand} left by one bit.
REQ-015 The iteration counter SHALL decrement once per iteration; CONV SHALL exit to DONE on the edge on which the counter reaches zero.
REQ-016 On the edge entering DONE (k+DATA_W), bcd_out SHALL load the scratch digits, and done SHALL be high for exactly the following cycle.
REQ-017 DONE SHALL last one cycle and then return to IDLE unconditionally.
REQ-018 Latency SHALL be DATA_W+1 cycles from the accepting edge to the done cycle (14 cycles at default parameters).
REQ-019 start asserted in CONV or DONE SHALL be ignored and SHALL NOT be queued.
REQ-020 A new conversion SHALL be accepted no earlier than the first IDLE cycle after done, giving a maximum throughput of one result per DATA_W+2 cycles.
REQ-021 bcd_out SHALL hold its last result until the next DONE entry; bin_in changing during CONV SHALL have no effect.
REQ-022 busy SHALL be 1 exactly in CONV; done SHALL be 1 exactly in DONE; busy and done SHALL never be high together.
REQ-023 At default parameters the maximum input (8191) is below 10^DIGITS; no overflow flag exists, and every DATA_W-bit input SHALL convert exactly.
REQ-024 Scratch digit width SHALL be 4 bits; an add-3 correction SHALL never carry out of a digit.

Reset
REQ-025 rst_n low SHALL asynchronously force state to IDLE and clear busy, done, bcd_out, the scratch register and the counter to 0.
REQ-026 Reset asserted during CONV or DONE SHALL abort the conversion with no done pulse; bcd_out SHALL read 0 after reset.
REQ-027 Following reset deassertion, the first start sampled in IDLE SHALL be accepted normally.

Structure
REQ-028 A shared package SHALL hold the state encoding (IDLE, CONV, DONE) and the default DATA_W and DIGITS constants.
REQ-029 The per-digit add-3 correction SHALL be a combinational sub-module bcd_digit_adj, instantiated DIGITS times.
REQ-030 The counter width SHALL be sized from DATA_W via the package; no magic numbers SHALL appear in the RTL.

Verification
REQ-031 Bench SHALL drive bin_in=5040 with start=1 for one cycle and require done exactly 14 cycles later with bcd_out=16'h5040 and busy high for 13 cycles.
REQ-032 Bench SHALL check the boundaries: bin_in=0 -> 16'h0000; bin_in=8191 -> 16'h8191; bin_in=343 -> 16'h0343; bin_in=49 -> 16'h0049.
REQ-033 Bench SHALL pulse start=1 with bin_in=100 during CONV of a 5040 conversion and require a single done with bcd_out=16'h5040 and no second done.
REQ-034 Bench SHALL hold start high continuously with bin_in=720 and require done every 15 cycles with bcd_out=16'h0720 each time.
REQ-035 Bench SHALL pull rst_n low at cycle 6 of a conversion and require busy=0, done=0 and bcd_out=0 immediately, with no done pulse; a following start with bin_in=24 SHALL give 16'h0024.
REQ-036 Bench SHALL sweep all 8192 inputs and compare each result against a reference decimal model with zero mismatches.

Source files
------------

// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM state encoding, default operand/digit sizing and counter sizing helper.
package bin_to_bcd_seq_pkg;

    // Default operand width (result of the square/cube/factorial stage)
    localparam int DEF_DATA_W = 13;
    // Default number of BCD digits produced
    localparam int DEF_DIGITS = 4;
    // Width of one BCD digit
    localparam int NIBBLE_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bits needed to hold the iteration count 0..data_w
    function automatic int cnt_width(input int data_w);
        return $clog2(data_w + 1);
    endfunction

endpackage

// File: rtl/bin_to_bcd_seq_digit_adj.sv
// Combinational double-dabble correction for one BCD digit: a digit of 5 or
// more gets 3 added so that the following left shift carries into the next
// digit exactly when the decimal value reaches 10. The largest input (9)
// becomes 12, so the correction never carries out of the nibble.
module bcd_digit_adj
    import bin_to_bcd_seq_pkg::*;
(
    input  logic [NIBBLE_W-1:0] digit_in,
    output logic [NIBBLE_W-1:0] digit_out
);

    localparam logic [NIBBLE_W-1:0] ADJ_THRESH = NIBBLE_W'(5);
    localparam logic [NIBBLE_W-1:0] ADJ_ADD    = NIBBLE_W'(3);

    // Add 3 to digits at or above 5, pass smaller digits unchanged
    always_comb begin
        digit_out = digit_in;
        if (digit_in >= ADJ_THRESH) begin
            digit_out = digit_in + ADJ_ADD;
        end else begin
            digit_out = digit_in;
        end
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter using shift-add-3 (double dabble).
// One iteration per clock: DATA_W iterations in CONV, then a one-cycle DONE
// with a done pulse. bcd_out holds the last result until the next DONE entry.
module bin_to_bcd_seq
    import bin_to_bcd_seq_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DIGITS = DEF_DIGITS
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [DATA_W-1:0]          bin_in,
    output logic                       busy,
    output logic                       done,
    output logic [NIBBLE_W*DIGITS-1:0] bcd_out
);

    localparam int BCD_W = NIBBLE_W * DIGITS;
    localparam int CNT_W = cnt_width(DATA_W);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    state_t             state_r;
    state_t             next_state_s;
    logic [DATA_W-1:0]  bin_r;
    logic [BCD_W-1:0]   scratch_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [BCD_W-1:0]   bcd_r;
    logic               busy_r;
    logic               done_r;

    logic [BCD_W-1:0]   adj_s;
    logic [BCD_W-1:0]   scratch_nxt_s;
    logic [DATA_W-1:0]  bin_nxt_s;
    logic               last_iter_s;

    // One correction cell per scratch digit
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_in  (scratch_r[g*NIBBLE_W +: NIBBLE_W]),
            .digit_out (adj_s[g*NIBBLE_W +: NIBBLE_W])
        );
    end

    // Shift the corrected digits and the operand left together by one bit;
    // the bit shifted out of the top digit is always zero for in-range inputs
    always_comb begin
        {scratch_nxt_s, bin_nxt_s} = {adj_s, bin_r} << 1;
    end

    // The iteration running while the counter reads one is the final one
    always_comb begin
        last_iter_s = 1'b0;
        if (cnt_r == CNT_ONE) begin
            last_iter_s = 1'b1;
        end else begin
            last_iter_s = 1'b0;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic: start only matters in IDLE, DONE always returns to IDLE
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    next_state_s = CONV;
                end else begin
                    next_state_s = IDLE;
                end
            end
            CONV: begin
                if (last_iter_s) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = CONV;
                end
            end
            DONE: begin
                next_state_s = IDLE;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Datapath: load on accept, iterate in CONV, publish the result on the last iteration
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_r     <= '0;
            scratch_r <= '0;
            cnt_r     <= CNT_ZERO;
            bcd_r     <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        bin_r     <= bin_in;
                        scratch_r <= '0;
                        cnt_r     <= CNT_LOAD;
                    end
                end
                CONV: begin
                    bin_r     <= bin_nxt_s;
                    scratch_r <= scratch_nxt_s;
                    cnt_r     <= cnt_r - CNT_ONE;
                    if (last_iter_s) begin
                        bcd_r <= scratch_nxt_s;
                    end
                end
                default: begin
                    bin_r     <= bin_r;
                    scratch_r <= scratch_r;
                    cnt_r     <= cnt_r;
                end
            endcase
        end
    end

    // Status flags registered from the next state so they track the state exactly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (next_state_s == CONV);
            done_r <= (next_state_s == DONE);
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign bcd_out = bcd_r;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: stimulus pushes expected results with
// the cycle on which done must appear; a negedge monitor pops and compares.
// Four extra instances sweep the full 13-bit input range in parallel against
// a divide-by-ten decimal model.
module tb_bin_to_bcd_seq;

    localparam int DW  = 13;
    localparam int LAT = 13;   // accepting edge + LAT = edge that enters DONE
    localparam int NSW = 4;

    typedef struct {
        logic [15:0] bcd;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [12:0] bin_in;
    logic        busy;
    logic        done;
    logic [15:0] bcd_out;

    exp_t sb_q[$];
    int   cyc;
    int   n_vec;
    int   n_miss;
    int   busy_run;
    int   acc;

    logic        sweep_on;
    int          sw_v [NSW];
    int          sw_cnt;
    logic [NSW-1:0] sw_start;
    logic [NSW-1:0] sw_busy;
    logic [NSW-1:0] sw_done;
    logic [12:0] sw_bin [NSW];
    logic [15:0] sw_bcd [NSW];

    bin_to_bcd_seq dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .bin_in  (bin_in),
        .busy    (busy),
        .done    (done),
        .bcd_out (bcd_out)
    );

    for (genvar j = 0; j < NSW; j++) begin : g_sw
        assign sw_start[j] = sweep_on && (sw_v[j] < 8192);
        assign sw_bin[j]   = 13'(sw_v[j]);
        bin_to_bcd_seq u_sw (
            .clk     (clk),
            .rst_n   (rst_n),
            .start   (sw_start[j]),
            .bin_in  (sw_bin[j]),
            .busy    (sw_busy[j]),
            .done    (sw_done[j]),
            .bcd_out (sw_bcd[j])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] ref_bcd(input int v);
        logic [15:0] r;
        int          x;
        r = 16'h0000;
        x = v;
        for (int d = 0; d < 4; d++) begin
            r[d*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Main monitor: every done must match the head of the scoreboard
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_run = 0;
        end else if (done) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_done: got done=1 with bcd_out=0x%0h, expected no done", bcd_out);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("bcd_out", {16'h0000, bcd_out}, {16'h0000, e.bcd});
                chk("done_cycle", cyc, e.cyc);
                chk("busy_cycles", busy_run, LAT);
                chk("busy_with_done", {31'd0, busy}, 32'd0);
            end
            busy_run = 0;
        end else if (busy) begin
            busy_run = busy_run + 1;
        end else begin
            busy_run = 0;
        end
    end

    // Sweep monitor: compare each completed sweep conversion with the model
    always @(negedge clk) begin
        if (sweep_on) begin
            for (int j = 0; j < NSW; j++) begin
                if (sw_done[j]) begin
                    chk($sformatf("sweep_%0d", sw_v[j]), {16'h0000, sw_bcd[j]},
                        {16'h0000, ref_bcd(sw_v[j])});
                    sw_v[j] = sw_v[j] + NSW;
                    sw_cnt  = sw_cnt + 1;
                end
            end
        end
    end

    task automatic issue(input logic [12:0] v, input logic [15:0] exp);
        @(negedge clk);
        start  = 1'b1;
        bin_in = v;
        sb_q.push_back('{bcd: exp, cyc: cyc + 1 + LAT});
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(negedge clk);
        if (sb_q.size() != 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL drain_timeout: got %0d pending results, expected 0", sb_q.size());
            sb_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    function automatic bit sweep_finished();
        for (int j = 0; j < NSW; j++) if (sw_v[j] < 8192) return 1'b0;
        return 1'b1;
    endfunction

    initial begin
        n_vec    = 0;
        n_miss   = 0;
        cyc      = 0;
        busy_run = 0;
        sw_cnt   = 0;
        sweep_on = 1'b0;
        for (int j = 0; j < NSW; j++) sw_v[j] = j;
        rst_n  = 1'b0;
        start  = 1'b0;
        bin_in = 13'd0;
        repeat (3) @(negedge clk);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_bcd", {16'h0000, bcd_out}, 32'h0000);
        rst_n = 1'b1;
        @(negedge clk);

        // Main vector and boundaries
        issue(13'd5040, 16'h5040); drain();
        issue(13'd0,    16'h0000); drain();
        issue(13'd8191, 16'h8191); drain();
        issue(13'd343,  16'h0343); drain();
        issue(13'd49,   16'h0049); drain();

        // start during CONV is ignored; bin_in changing mid-conversion has no effect
        issue(13'd5040, 16'h5040);
        repeat (3) @(negedge clk);
        start  = 1'b1;
        bin_in = 13'd100;
        @(negedge clk);
        start = 1'b0;
        drain();
        repeat (20) @(negedge clk);

        // start held high: one accept every DATA_W+2 cycles
        @(negedge clk);
        acc    = cyc + 1;
        start  = 1'b1;
        bin_in = 13'd720;
        for (int i = 0; i < 4; i++) sb_q.push_back('{bcd: 16'h0720, cyc: acc + 15*i + LAT});
        for (int i = 0; i < 100 && cyc < acc + 50; i++) @(negedge clk);
        start = 1'b0;
        drain();
        repeat (5) @(negedge clk);
        chk("idle_hold", {16'h0000, bcd_out}, 32'h0720);

        // Reset in the middle of a conversion aborts it
        @(negedge clk);
        acc    = cyc + 1;
        start  = 1'b1;
        bin_in = 13'd5040;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20 && cyc < acc + 5; i++) @(negedge clk);
        chk("busy_before_reset", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_bcd", {16'h0000, bcd_out}, 32'h0000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        issue(13'd24, 16'h0024); drain();

        // Exhaustive sweep on the parallel instances
        sweep_on = 1'b1;
        for (int i = 0; i < 40000 && !sweep_finished(); i++) @(negedge clk);
        sweep_on = 1'b0;
        chk("sweep_count", sw_cnt, 32'd8192);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
